// File: rtl/rf_read_arbiter.sv
// rf_read_arbiter: shares the single reg_file read port between two requesters
// (0 = MADcalc, 1 = second window consumer). Round-robin arbitration with
// burst locking, a bounded lock length and a response timeout.
module rf_read_arbiter #(
    parameter int unsigned POPSIZE    = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned MAX_BURST  = 20,
    localparam int unsigned AW        = (POPSIZE > 1) ? $clog2(POPSIZE) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    // requester 0
    input  logic                  m0_rqst,
    input  logic [AW-1:0]         m0_addr,
    input  logic                  m0_lock,
    output logic                  m0_gnt,
    output logic                  m0_vld,
    // requester 1
    input  logic                  m1_rqst,
    input  logic [AW-1:0]         m1_addr,
    input  logic                  m1_lock,
    output logic                  m1_gnt,
    output logic                  m1_vld,
    // shared response data
    output logic [DATA_WIDTH-1:0] rd_data,
    // reg_file read port
    output logic                  rf_rd_rqst,
    output logic [AW-1:0]         rf_read_addr,
    input  logic                  rf_data_vld,
    input  logic [DATA_WIDTH-1:0] rf_data_out,
    // status
    output logic                  timeout_err,
    output logic                  busy
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        LOCK
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic [TW-1:0]         tmo_q, tmo_d;

    logic                  gnt0_q, gnt0_d;
    logic                  gnt1_q, gnt1_d;
    logic                  vld0_q, vld0_d;
    logic                  vld1_q, vld1_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rf_rqst_q, rf_rqst_d;
    logic [AW-1:0]         rf_addr_q, rf_addr_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;

    // Views of the current owner's request lines
    logic                  own_rqst;
    logic                  own_lock;
    logic [AW-1:0]         own_addr;
    logic                  pick;
    logic [TW-1:0]         tmo_inc;
    logic [BW-1:0]         burst_inc;

    assign own_rqst  = owner_q ? m1_rqst : m0_rqst;
    assign own_lock  = owner_q ? m1_lock : m0_lock;
    assign own_addr  = owner_q ? m1_addr : m0_addr;
    // Sole requester wins; on contention the one that was not served last wins
    assign pick      = (m0_rqst && m1_rqst) ? ~last_q : m1_rqst;
    assign tmo_inc   = tmo_q + TW'(1);
    assign burst_inc = burst_q + BW'(1);

    // Next-state and registered-output computation
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        burst_d   = burst_q;
        tmo_d     = tmo_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        vld0_d    = 1'b0;
        vld1_d    = 1'b0;
        rd_data_d = rd_data_q;
        rf_rqst_d = 1'b0;
        rf_addr_d = rf_addr_q;
        err_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (m0_rqst || m1_rqst) begin
                    owner_d   = pick;
                    gnt0_d    = ~pick;
                    gnt1_d    = pick;
                    rf_addr_d = pick ? m1_addr : m0_addr;
                    rf_rqst_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // rf_rd_rqst was raised on entry and falls on exit
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A response in the expiry cycle still wins over the timeout
                if (rf_data_vld) begin
                    rd_data_d = rf_data_out;
                    vld0_d    = ~owner_q;
                    vld1_d    = owner_q;
                    state_d   = RESP;
                end else if (tmo_inc == TW'(TIMEOUT)) begin
                    tmo_d   = '0;
                    err_d   = 1'b1;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    last_d  = owner_q;
                    burst_d = '0;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            RESP: begin
                if (own_lock && (burst_inc < BW'(MAX_BURST))) begin
                    burst_d = burst_inc;
                    state_d = LOCK;
                end else begin
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    last_d  = owner_q;
                    burst_d = '0;
                    state_d = IDLE;
                end
            end
            LOCK: begin
                if (own_rqst) begin
                    rf_addr_d = own_addr;
                    rf_rqst_d = 1'b1;
                    state_d   = ISSUE;
                end else if (!own_lock) begin
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    last_d  = owner_q;
                    burst_d = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            burst_q   <= '0;
            tmo_q     <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            vld0_q    <= 1'b0;
            vld1_q    <= 1'b0;
            rd_data_q <= '0;
            rf_rqst_q <= 1'b0;
            rf_addr_q <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            burst_q   <= burst_d;
            tmo_q     <= tmo_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            vld0_q    <= vld0_d;
            vld1_q    <= vld1_d;
            rd_data_q <= rd_data_d;
            rf_rqst_q <= rf_rqst_d;
            rf_addr_q <= rf_addr_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign m0_gnt       = gnt0_q;
    assign m1_gnt       = gnt1_q;
    assign m0_vld       = vld0_q;
    assign m1_vld       = vld1_q;
    assign rd_data      = rd_data_q;
    assign rf_rd_rqst   = rf_rqst_q;
    assign rf_read_addr = rf_addr_q;
    assign timeout_err  = err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed bench for rf_read_arbiter. Instance a uses default parameters,
// instance b uses MAX_BURST=4. Both share requester stimulus and each has its
// own reg_file model returning 0xA2 + address one cycle after rf_rd_rqst.
module tb_rf_read_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_rqst, m0_lock, m1_rqst, m1_lock;
    logic [3:0] m0_addr, m1_addr;
    logic       rf_en, rf_late;

    logic       a_m0_gnt, a_m0_vld, a_m1_gnt, a_m1_vld;
    logic [7:0] a_rd_data, a_rf_data;
    logic       a_rf_rd_rqst, a_timeout_err, a_busy, a_rf_vld;
    logic [3:0] a_rf_read_addr;

    logic       b_m0_gnt, b_m0_vld, b_m1_gnt, b_m1_vld;
    logic [7:0] b_rd_data, b_rf_data;
    logic       b_rf_rd_rqst, b_timeout_err, b_busy, b_rf_vld;
    logic [3:0] b_rf_read_addr;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rf_read_arbiter u_a (
        .clk(clk), .rst(rst),
        .m0_rqst(m0_rqst), .m0_addr(m0_addr), .m0_lock(m0_lock),
        .m0_gnt(a_m0_gnt), .m0_vld(a_m0_vld),
        .m1_rqst(m1_rqst), .m1_addr(m1_addr), .m1_lock(m1_lock),
        .m1_gnt(a_m1_gnt), .m1_vld(a_m1_vld),
        .rd_data(a_rd_data),
        .rf_rd_rqst(a_rf_rd_rqst), .rf_read_addr(a_rf_read_addr),
        .rf_data_vld(a_rf_vld | rf_late), .rf_data_out(a_rf_data),
        .timeout_err(a_timeout_err), .busy(a_busy)
    );

    rf_read_arbiter #(.MAX_BURST(4)) u_b (
        .clk(clk), .rst(rst),
        .m0_rqst(m0_rqst), .m0_addr(m0_addr), .m0_lock(m0_lock),
        .m0_gnt(b_m0_gnt), .m0_vld(b_m0_vld),
        .m1_rqst(m1_rqst), .m1_addr(m1_addr), .m1_lock(m1_lock),
        .m1_gnt(b_m1_gnt), .m1_vld(b_m1_vld),
        .rd_data(b_rd_data),
        .rf_rd_rqst(b_rf_rd_rqst), .rf_read_addr(b_rf_read_addr),
        .rf_data_vld(b_rf_vld | rf_late), .rf_data_out(b_rf_data),
        .timeout_err(b_timeout_err), .busy(b_busy)
    );

    // reg_file models: one-cycle read latency, contents = 0xA2 + address
    always @(posedge clk) begin
        a_rf_vld  <= a_rf_rd_rqst & rf_en;
        a_rf_data <= 8'hA2 + {4'h0, a_rf_read_addr};
        b_rf_vld  <= b_rf_rd_rqst & rf_en;
        b_rf_data <= 8'hA2 + {4'h0, b_rf_read_addr};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: state IDLE, inputs applied from here on
    task automatic do_reset();
        rst = 1'b1;
        m0_rqst = 1'b0; m0_lock = 1'b0; m0_addr = '0;
        m1_rqst = 1'b0; m1_lock = 1'b0; m1_addr = '0;
        rf_en = 1'b1; rf_late = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ev;
        int   j;
        a_rf_vld = 1'b0; b_rf_vld = 1'b0;
        a_rf_data = '0;  b_rf_data = '0;

        // ---- single transaction ----
        do_reset();
        check("rst_outs", {a_m0_gnt, a_m1_gnt, a_m0_vld, a_m1_vld, a_rf_rd_rqst, a_timeout_err, a_busy}, 0);
        check("rst_data", {a_rd_data, a_rf_read_addr}, 0);
        m0_rqst = 1'b1; m0_addr = 4'd3;
        step();
        check("s1_gnt", a_m0_gnt, 1);
        check("s1_rfrq", a_rf_rd_rqst, 1);
        check("s1_addr", a_rf_read_addr, 3);
        check("s1_busy", a_busy, 1);
        step();
        check("s2_rfrq", a_rf_rd_rqst, 0);
        check("s2_vld", a_m0_vld, 0);
        step();
        check("s3_vld", a_m0_vld, 1);
        check("s3_data", a_rd_data, 8'hA5);
        m0_rqst = 1'b0;
        step();
        check("s4_gnt", a_m0_gnt, 0);
        check("s4_vld", a_m0_vld, 0);
        check("s4_busy", a_busy, 0);

        // ---- contention, then m0 re-asserts and m1 goes first ----
        do_reset();
        m0_rqst = 1'b1; m0_addr = 4'd1;
        m1_rqst = 1'b1; m1_addr = 4'd2;
        for (int i = 0; i <= 12; i++) begin
            check($sformatf("ct_m0v_c%0d", i), a_m0_vld, (i == 3) || (i == 11));
            check($sformatf("ct_m1v_c%0d", i), a_m1_vld, i == 7);
            check($sformatf("ct_m0g_c%0d", i), a_m0_gnt, (i >= 1 && i <= 3) || (i >= 9 && i <= 11));
            check($sformatf("ct_m1g_c%0d", i), a_m1_gnt, i >= 5 && i <= 7);
            if (i == 3)  check("ct_d3", a_rd_data, 8'hA3);
            if (i == 7)  check("ct_d7", a_rd_data, 8'hA4);
            if (i == 11) check("ct_d11", a_rd_data, 8'hA6);
            if (i == 3)  m0_addr = 4'd4;
            if (i == 7)  m1_rqst = 1'b0;
            if (i == 11) m0_rqst = 1'b0;
            step();
        end

        // ---- burst lock: 10 reads addr 0..9 while m1 waits ----
        do_reset();
        m0_rqst = 1'b1; m0_lock = 1'b1; m0_addr = 4'd0;
        m1_rqst = 1'b1; m1_addr = 4'd7;
        for (int i = 0; i <= 45; i++) begin
            ev = (i >= 3) && (i <= 39) && (((i - 3) % 4) == 0);
            j  = (i - 3) / 4;
            check($sformatf("bl_m0v_c%0d", i), a_m0_vld, ev);
            check($sformatf("bl_m0g_c%0d", i), a_m0_gnt, i >= 1 && i <= 39);
            check($sformatf("bl_m1g_c%0d", i), a_m1_gnt, i >= 41 && i <= 43);
            check($sformatf("bl_m1v_c%0d", i), a_m1_vld, i == 43);
            if (ev) check($sformatf("bl_d_c%0d", i), a_rd_data, 8'hA2 + j);
            if (i == 43) check("bl_m1d", a_rd_data, 8'hA9);
            if (ev) begin
                if (j == 9) begin
                    m0_rqst = 1'b0; m0_lock = 1'b0;
                end else begin
                    m0_addr = 4'(j + 1);
                end
            end
            if (i == 43) m1_rqst = 1'b0;
            step();
        end

        // ---- MAX_BURST=4 on instance b ----
        do_reset();
        m0_rqst = 1'b1; m0_lock = 1'b1; m0_addr = 4'd0;
        m1_rqst = 1'b1; m1_addr = 4'd5;
        j = 0;
        for (int i = 0; i <= 25; i++) begin
            ev = (i == 3) || (i == 7) || (i == 11) || (i == 15) || (i == 23);
            check($sformatf("mb_m0v_c%0d", i), b_m0_vld, ev);
            check($sformatf("mb_m1v_c%0d", i), b_m1_vld, i == 19);
            check($sformatf("mb_m0g_c%0d", i), b_m0_gnt, (i >= 1 && i <= 15) || (i >= 21 && i <= 23));
            check($sformatf("mb_m1g_c%0d", i), b_m1_gnt, i >= 17 && i <= 19);
            if (ev) check($sformatf("mb_d_c%0d", i), b_rd_data, 8'hA2 + j);
            if (i == 19) check("mb_m1d", b_rd_data, 8'hA7);
            if (ev && i != 23) begin
                j++;
                m0_addr = 4'(j);
            end
            if (i == 19) m1_rqst = 1'b0;
            if (i == 23) begin
                m0_rqst = 1'b0; m0_lock = 1'b0;
            end
            step();
        end

        // ---- timeout: reg_file silent, m1 pending ----
        do_reset();
        rf_en = 1'b0;
        m0_rqst = 1'b1; m0_addr = 4'd2;
        m1_rqst = 1'b1; m1_addr = 4'd6;
        for (int i = 0; i <= 22; i++) begin
            check($sformatf("to_err_c%0d", i), a_timeout_err, i == 18);
            check($sformatf("to_m0v_c%0d", i), a_m0_vld, 0);
            check($sformatf("to_m0g_c%0d", i), a_m0_gnt, i >= 1 && i <= 17);
            check($sformatf("to_m1g_c%0d", i), a_m1_gnt, i >= 19 && i <= 21);
            check($sformatf("to_m1v_c%0d", i), a_m1_vld, i == 21);
            check($sformatf("to_busy_c%0d", i), a_busy, (i >= 1 && i <= 17) || (i >= 19 && i <= 21));
            if (i == 21) check("to_m1d", a_rd_data, 8'hA8);
            if (i == 18) rf_en = 1'b1;
            if (i == 21) begin
                m0_rqst = 1'b0; m1_rqst = 1'b0;
            end
            step();
        end

        // ---- reset during WAIT, late response ignored ----
        do_reset();
        rf_en = 1'b0;
        m0_rqst = 1'b1; m0_addr = 4'd3;
        step(); step(); step(); step();
        check("rw_busy", a_busy, 1);
        rst = 1'b1;
        step();
        check("rw_outs", {a_m0_gnt, a_m1_gnt, a_m0_vld, a_m1_vld, a_rf_rd_rqst, a_timeout_err, a_busy}, 0);
        check("rw_data", {a_rd_data, a_rf_read_addr}, 0);
        rst = 1'b0; rf_late = 1'b1; m0_rqst = 1'b0;
        step();
        rf_late = 1'b0;
        check("rw_late", {a_m0_gnt, a_m1_gnt, a_m0_vld, a_m1_vld, a_rf_rd_rqst, a_timeout_err, a_busy}, 0);
        check("rw_late_d", a_rd_data, 0);
        rf_en = 1'b1; m0_rqst = 1'b1; m0_addr = 4'd8;
        step();
        check("rw_gnt", a_m0_gnt, 1);
        check("rw_addr", {a_rf_rd_rqst, a_rf_read_addr}, {1'b1, 4'd8});
        step(); step();
        check("rw_vld", a_m0_vld, 1);
        check("rw_d", a_rd_data, 8'hAA);
        m0_rqst = 1'b0;
        step();
        check("rw_end", {a_m0_gnt, a_busy}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_read_arbiter.md
Name: rf_read_arbiter

Overview:
- Shares the single reg_file read port (read_addr / rd_rqst / data_vld / data_out) between two requesters.
- Requester 0 is MADcalc. Requester 1 is a second window consumer, e.g. an outlier/threshold checker.
- Arbitration is round-robin with burst locking, so MADcalc can hold the port across a full window pass.
- A response timeout guards against a hung reg_file.

Parameters:
- POPSIZE, 10, window depth; address width AW = $clog2(POPSIZE).
- DATA_WIDTH, 8, sample width.
- TIMEOUT, 16, max cycles in WAIT before abort.
- MAX_BURST, 20, max consecutive locked transactions before forced release.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- m0_rqst  in  1  requester 0 read request; level, held until m0_vld or timeout_err.
- m0_addr  in  AW  requester 0 address; stable while m0_rqst high.
- m0_lock  in  1  requester 0 keeps grant after current transaction.
- m0_gnt  out  1  requester 0 owns port.
- m0_vld  out  1  one-cycle response strobe to requester 0.
- m1_rqst, m1_addr, m1_lock, m1_gnt, m1_vld: same as requester 0, for requester 1.
- rd_data  out  DATA_WIDTH  response data, shared; valid with mX_vld.
- rf_rd_rqst  out  1  to reg_file rd_rqst.
- rf_read_addr  out  AW  to reg_file read_addr.
- rf_data_vld  in  1  from reg_file data_vld.
- rf_data_out  in  DATA_WIDTH  from reg_file data_out.
- timeout_err  out  1  one-cycle abort pulse.
- busy  out  1  state != IDLE.

Behaviour:
- All outputs are registered.
- Reset values: every output 0, state IDLE, owner 0, last 1 (requester 0 wins first), burst count 0, timeout count 0.
- States:
  - IDLE: if any rqst, grant by round-robin. Sole requester wins; if both, the one != last wins. Latch owner and address, assert owner gnt, go ISSUE.
  - ISSUE: rf_rd_rqst=1 for exactly this cycle, rf_read_addr=latched addr; clear timeout count; go WAIT.
  - WAIT:
    - On rf_data_vld: capture rf_data_out into rd_data, go RESP.
    - Otherwise increment the timeout count. When it reaches TIMEOUT: timeout_err=1 for one cycle, drop gnt, last=owner, burst count=0, go IDLE.
    - rf_data_vld in the expiry cycle wins over timeout.
  - RESP: owner vld=1 for one cycle, rd_data held. Increment the burst count.
    - If owner lock=1 and burst count < MAX_BURST: go LOCK.
    - Else: drop gnt, last=owner, burst count=0, go IDLE.
  - LOCK: gnt held.
    - If owner rqst=1: latch addr, go ISSUE with no re-arbitration.
    - Else if owner lock=0: release, last=owner, burst count=0, go IDLE.
    - The non-owner waits.
- Request handshake:
  - A rqst seen high in IDLE or LOCK is a new request.
  - The requester drops rqst at the edge where it samples vld=1, or re-asserts for back-to-back.
  - Requester rqst is never sampled in ISSUE, WAIT or RESP.
- Latency: with reg_file 1-cycle response, rqst high in cycle 0 (IDLE) gives rf_rd_rqst in cycle 1, vld in cycle 3.
  - In LOCK, the same 3-cycle cadence applies from LOCK to vld.
- rd_data holds its last value; it is meaningful only with vld.
- rf_data_vld outside WAIT is ignored.
- Addresses are passed unmodified; range checking is the requester's job.
- Timeout releases any lock. The aborted requester retries via normal arbitration at lower priority.
- Reset mid-operation: return to IDLE next edge, all outputs 0. A late reg_file response is ignored.

Test Plan:
- Single: m0_rqst=1, m0_addr=3; model reg_file returns 0xA5 one cycle after rf_rd_rqst. Expect:
  - m0_gnt cycle 1, rf_rd_rqst=1 with rf_read_addr=3 in cycle 1.
  - m0_vld=1 with rd_data=0xA5 in cycle 3.
  - gnt=0 in cycle 4.
- Contention: m0 and m1 request together from reset.
  - m0 served first, m1 second (vld cycles 3 and 7).
  - Repeat the contention: m1 served first.
- Burst lock: m0_lock=1, 10 back-to-back reads addr 0..9 while m1_rqst=1. Expect:
  - 10 m0_vld pulses, 4 cycles apart, data matches addresses.
  - m1 is granted only after m0_lock drops.
- MAX_BURST=4 with a lock held: after the 4th m0_vld, gnt moves to the pending m1; m0 is re-granted after m1's response.
- Timeout: reg_file never responds. Expect:
  - timeout_err pulse exactly 16 cycles after entering WAIT, no m0_vld, state IDLE.
  - Concurrent m1 granted next.
- Reset during WAIT, then a late rf_data_vld: no vld pulse, all outputs 0, next m0 request served normally.
